// File: rtl/llc_trace_req_queue.sv
// Trace command queue feeding the LLC model: filters illegal ops, splits addresses
// into tag/index/offset and holds the stream at op 9 until the dump is acknowledged.
module llc_trace_req_queue #(
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 14
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [3:0]                                in_op,
    input  logic [ADDR_WIDTH-1:0]                     in_addr,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [3:0]                                out_op,
    output logic [ADDR_WIDTH-1:0]                     out_addr,
    output logic [ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-1:0] out_tag,
    output logic [INDEX_BITS-1:0]                     out_index,
    output logic [OFFSET_BITS-1:0]                    out_offset,
    output logic                                      dump_req,
    input  logic                                      dump_done,
    output logic [$clog2(DEPTH):0]                    fifo_count,
    output logic [15:0]                               drop_count,
    output logic [31:0]                               issued_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DUMP} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_op   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_nxt;
    logic [CW-1:0]         r_count, w_count_nxt;
    logic [15:0]           r_drop;
    logic [31:0]           r_issued;
    logic                  w_accept, w_push, w_drop, w_pop;
    logic [3:0]            w_head_op_nxt;

    assign in_ready   = (r_count < CW'(DEPTH));
    assign w_accept   = in_valid && in_ready;
    assign w_push     = w_accept && (in_op <= 4'd9);
    assign w_drop     = w_accept && (in_op > 4'd9);

    assign out_op     = r_op[r_rd_ptr];
    assign out_addr   = r_addr[r_rd_ptr];
    assign out_tag    = out_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    assign out_index  = out_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign out_offset = out_addr[OFFSET_BITS-1:0];

    assign fifo_count   = r_count;
    assign drop_count   = r_drop;
    assign issued_count = r_issued;

    // Next state is decided from the head as it will be after this edge, so the
    // registered state already reflects a newly visible head on cycle N+1.
    always_comb begin
        w_pop     = 1'b0;
        out_valid = 1'b0;
        dump_req  = 1'b0;
        case (r_state)
            S_ISSUE: begin
                out_valid = 1'b1;
                w_pop     = out_ready;
            end
            S_DUMP: begin
                dump_req = 1'b1;
                w_pop    = dump_done;
            end
            default: ;
        endcase
        w_rd_nxt      = r_rd_ptr + PW'(w_pop);
        w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
        w_head_op_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? in_op : r_op[w_rd_nxt];
        if (w_count_nxt == '0)
            w_state_nxt = S_IDLE;
        else if (w_head_op_nxt == 4'd9)
            w_state_nxt = S_DUMP;
        else
            w_state_nxt = S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_issued <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_drop && (r_drop != '1))
                r_drop <= r_drop + 16'd1;
            if (w_pop)
                r_issued <= r_issued + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op[r_wr_ptr]   <= in_op;
            r_addr[r_wr_ptr] <= in_addr;
        end
    end
endmodule

// File: doc/llc_trace_req_queue.md
Name: llc_trace_req_queue

Overview:
- Upstream stage of the LLC model: buffers trace commands {op, address} parsed from the .din trace file and presents them one at a time to the LLC with a valid/ready handshake.
- Filters illegal op codes.
- Splits each address into tag/index/offset per LLC geometry.
- Treats op 9 (print cache contents) as a barrier: holds the stream until the dump is acknowledged.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ADDR_WIDTH, 32, trace address width.
- OFFSET_BITS, 6, byte-offset bits (64 B line).
- INDEX_BITS, 14, set-index bits (16384 sets); tag width = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  trace command offered.
- in_ready  out  1  queue can accept a command.
- in_op  in  4  trace op code (legal 0..9).
- in_addr  in  ADDR_WIDTH  trace address.
- out_valid  out  1  LLC request valid (never for op 9).
- out_ready  in  1  LLC accepts request.
- out_op  out  4  op of head entry (0..8).
- out_addr  out  ADDR_WIDTH  address of head entry.
- out_tag  out  ADDR_WIDTH-INDEX_BITS-OFFSET_BITS  out_addr tag field.
- out_index  out  INDEX_BITS  out_addr set field.
- out_offset  out  OFFSET_BITS  out_addr offset field.
- dump_req  out  1  request cache-content print (op 9 at head).
- dump_done  in  1  print complete, one-cycle pulse.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- drop_count  out  16  illegal ops discarded, saturating.
- issued_count  out  32  requests handed to LLC, incl. op 9, wrapping.

Behaviour:
- Reset (rst high at posedge) clears to 0: pointers, fifo_count, drop_count, issued_count, out_valid, dump_req. FSM goes to IDLE.
- in_ready is 1 on the first cycle after reset.
- Reset mid-dump drops dump_req next cycle and discards all queued entries.
- in_ready = (fifo_count < DEPTH); combinational from registered count.
- Push: in_valid && in_ready at posedge.
  - in_op <= 9: entry written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - in_op > 9: nothing stored; drop_count += 1, saturating at 16'hFFFF.
- Latency: an entry pushed at edge N is visible at the head from cycle N+1 (first-word fall-through from registered storage).
- out_op, out_addr and field outputs are combinational from the head entry.
  - out_tag = addr[ADDR_WIDTH-1 : OFFSET_BITS+INDEX_BITS]; out_index = addr[OFFSET_BITS+INDEX_BITS-1 : OFFSET_BITS]; out_offset = addr[OFFSET_BITS-1:0].
- FSM states:
  - IDLE: fifo empty; out_valid=0, dump_req=0. Go to ISSUE if the head op is 0..8, DUMP if the head op is 9, on the cycle the head becomes valid.
  - ISSUE: out_valid=1. On out_ready: pop and issued_count += 1, then go to ISSUE/DUMP/IDLE per the next head, evaluated in the following cycle.
  - ISSUE hold rule: out_op/out_addr stable while out_valid && !out_ready.
  - DUMP: out_valid=0, dump_req=1. On dump_done: pop, issued_count += 1, dump_req=0 next cycle, then re-evaluate the head. dump_done outside DUMP is ignored.
- Simultaneous push and pop in one cycle: fifo_count unchanged, both pointers advance.
- A push into an empty queue plus an LLC-side pop in the same cycle cannot occur; the head is not valid until N+1.
- Full: in_ready=0 and the upstream holds its data. A pop while full frees a slot, and in_ready rises the next cycle (no same-cycle pass-through).
- out_valid and dump_req are never high together.

Test Plan:
- Reset, push {0,0x1234_5678} with out_ready=1 -> out_valid from cycle+1; out_tag=0x123, out_index=0x1159, out_offset=0x38; issued_count=1; fifo_count back to 0.
- out_ready=0, push 8 legal ops -> fifo_count=8, in_ready=0; 9th offer held. Then out_ready=1 -> 8 pops in trace order, pointer wrap verified, in_ready=1 one cycle after the first pop.
- Push ops {3, 12, 15, 1} -> only 3 and 1 issued, drop_count=2; 65537 illegal ops -> drop_count=16'hFFFF.
- Push {2,A},{9,0},{4,B}: after op 2 issues, dump_req=1 and out_valid=0. Hold dump_done low 5 cycles -> op 4 not issued. Pulse dump_done -> op 4 presented the cycle after dump_req falls; issued_count=3.
- Continuous push+pop at half occupancy for 20 cycles -> fifo_count constant, order preserved, issued_count=20.
- Assert rst during DUMP with 3 entries queued -> next cycle dump_req=0, out_valid=0, fifo_count=0, counters 0, in_ready=1.
